// File: rtl/sensor_report_pkg.sv
// sensor_report_pkg: shared FSM state, ASCII constants and frame sizing helpers
package sensor_report_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, CONV, SEND} state_t;
   localparam logic [7:0] COLON = 8'h3A;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] LF    = 8'h0A;
   localparam logic [7:0] ZERO  = 8'h30;
   function automatic int frame_len(input int digits);
      return digits + 4;
   endfunction
   function automatic longint pow10(input int digits);
      longint p = 1;
      for (int i = 0; i < digits; i++) p = p * 10;
      return p;
   endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one bit per cycle
module bin2bcd_seq #(
   parameter int DATA_W = 12,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     value,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);
   localparam int CW = $clog2(DATA_W + 1);
   logic                run_q, run_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0]   sh_q, sh_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
   // Load on start, then one add-3/shift step per cycle; done flags the final step
   always_comb begin
      adj = bcd_q;
      for (int d = 0; d < DIGITS; d++)
         adj[4*d +: 4] = (bcd_q[4*d +: 4] >= 4'd5) ? bcd_q[4*d +: 4] + 4'd3 : bcd_q[4*d +: 4];
      done = run_q && cnt_q == CW'(DATA_W - 1);
      run_d = start | (run_q & ~done);
      cnt_d = start ? '0 : cnt_q + CW'(run_q);
      {bcd_d, sh_d} = start ? {{4*DIGITS{1'b0}}, value} : run_q ? ({adj, sh_q} << 1) : {bcd_q, sh_q};
   end
   // Converter state registers
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         sh_q  <= '0;
         bcd_q <= '0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
         bcd_q <= bcd_d;
      end
   assign bcd = bcd_q;
endmodule

// File: rtl/sensor_report_tx.sv
// sensor_report_tx: round-robin multi-channel sensor value to ASCII UART frame sender
module sensor_report_tx
   import sensor_report_pkg::*;
#(
   parameter int         N_CH     = 2,
   parameter int         DATA_W   = 12,
   parameter int         DIGITS   = 4,
   parameter logic [7:0] TAG_BASE = 8'h41
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          i_done,
   input  logic [N_CH*DATA_W-1:0]   i_data,
   input  logic                     i_tx_full,
   output logic                     o_push,
   output logic [7:0]               o_tx_data,
   output logic                     o_busy,
   output logic [N_CH-1:0]          o_drop
);
   localparam int     PW  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int     FL  = frame_len(DIGITS);
   localparam int     IW  = $clog2(FL + 1);
   localparam longint LIM = pow10(DIGITS);
   state_t              state_q, state_d;
   logic [N_CH-1:0]     pending_q, pending_d, take;
   logic [DATA_W-1:0]   shadow_q [N_CH];
   logic [DATA_W-1:0]   shadow_d [N_CH];
   logic [PW-1:0]       ptr_q, ptr_d, gnt;
   logic [IW-1:0]       idx_q, idx_d;
   logic [DATA_W-1:0]   sat;
   logic                conv_done, last;
   logic [4*DIGITS-1:0] bcd;
   logic [3:0]          dig;
   // Round-robin grant starting after the last served channel, plus saturation of the granted value
   always_comb begin
      gnt = ptr_q;
      for (int i = N_CH; i >= 1; i--)
         if (pending_q[(int'(ptr_q) + i) % N_CH]) gnt = PW'((int'(ptr_q) + i) % N_CH);
      sat = (64'(shadow_q[gnt]) >= LIM) ? DATA_W'(LIM - 1) : shadow_q[gnt];
   end
   // Shadow capture and pending bookkeeping; a fresh sample arriving during its own grant stays pending
   always_comb begin
      take = '0;
      pending_d = pending_q;
      o_drop = '0;
      for (int k = 0; k < N_CH; k++) begin
         take[k] = state_q == LOAD && int'(gnt) == k;
         pending_d[k] = i_done[k] | (pending_q[k] & ~take[k]);
         shadow_d[k] = i_done[k] ? i_data[k*DATA_W +: DATA_W] : shadow_q[k];
         o_drop[k] = i_done[k] & pending_q[k] & ~take[k];
      end
      ptr_d = (state_q == LOAD) ? gnt : ptr_q;
   end
   // Next-state logic; IDLE looks at incoming pulses so LOAD follows the capture edge directly
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|(pending_q | i_done)) state_d = LOAD;
         LOAD:    state_d = CONV;
         CONV:    if (conv_done) state_d = SEND;
         SEND:    if (last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // Frame byte selection and push handshake; byte index only moves on an accepted push
   always_comb begin
      dig = '0;
      for (int d = 0; d < DIGITS; d++)
         if (int'(idx_q) == DIGITS + 1 - d) dig = bcd[4*d +: 4];
      o_push = (state_q == SEND) & ~i_tx_full;
      o_busy = state_q != IDLE;
      o_tx_data = (state_q != SEND)              ? 8'h00 :
                  (idx_q == '0)                  ? TAG_BASE + 8'(ptr_q) :
                  (int'(idx_q) == 1)             ? COLON :
                  (int'(idx_q) == DIGITS + 2)    ? CR :
                  (int'(idx_q) == DIGITS + 3)    ? LF : ZERO + {4'h0, dig};
      last = o_push && int'(idx_q) == FL - 1;
      idx_d = (state_q != SEND) ? '0 : idx_q + IW'(o_push);
   end
   // State registers
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         ptr_q     <= PW'(N_CH - 1);
         idx_q     <= '0;
         for (int k = 0; k < N_CH; k++) shadow_q[k] <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
      end
   bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (state_q == LOAD),
      .value (sat),
      .done  (conv_done),
      .bcd   (bcd)
   );
endmodule

// File: tb/tb_sensor_report_tx.sv
// tb_sensor_report_tx: directed checks of frames, arbitration, stall, drop, saturation and reset
module tb_sensor_report_tx;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  i_done = '0;
   logic [1:0]  d3_done = '0;
   logic [23:0] i_data = '0;
   logic [23:0] d3_data = '0;
   logic        i_tx_full = 1'b0;
   logic        o_push, o_busy, p3, b3;
   logic [7:0]  o_tx_data, t3;
   logic [1:0]  o_drop, dr3;
   int n_tests = 0, n_fail = 0, cyc = 0, t0 = 0, np = 0;

   sensor_report_tx dut (
      .clk(clk), .rst(rst), .i_done(i_done), .i_data(i_data), .i_tx_full(i_tx_full),
      .o_push(o_push), .o_tx_data(o_tx_data), .o_busy(o_busy), .o_drop(o_drop)
   );
   sensor_report_tx #(.DIGITS(3)) dut3 (
      .clk(clk), .rst(rst), .i_done(d3_done), .i_data(d3_data), .i_tx_full(1'b0),
      .o_push(p3), .o_tx_data(t3), .o_busy(b3), .o_drop(dr3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_done(input bit sel, input logic [1:0] m, input logic [11:0] v0, input logic [11:0] v1);
      step();
      if (sel) begin
         d3_done = m;
         d3_data = {v1, v0};
      end else begin
         i_done = m;
         i_data = {v1, v0};
      end
      t0 = cyc;
      step();
      i_done = '0;
      d3_done = '0;
   endtask

   task automatic expect_frame(input bit sel, input string name, input logic [7:0] tagc, input string digs,
                               input int lat, input int stall_at, input int stall_len);
      logic [7:0] exp[$];
      int idx, stall, n;
      logic push;
      logic [7:0] data;
      exp = {tagc, 8'h3A};
      for (int i = 0; i < digs.len(); i++) exp.push_back(digs[i]);
      exp.push_back(8'h0D);
      exp.push_back(8'h0A);
      idx = 0;
      stall = 0;
      n = 0;
      while (idx < exp.size() && n < 300) begin
         step();
         if (!sel) i_tx_full = (idx == stall_at && stall < stall_len);
         @(negedge clk);
         n++;
         push = sel ? p3 : o_push;
         data = sel ? t3 : o_tx_data;
         if (!sel && i_tx_full) begin
            check($sformatf("%s stall push", name), push, 0);
            check($sformatf("%s stall hold", name), data, exp[idx]);
            stall++;
         end else if (push) begin
            if (idx == 0 && lat >= 0) check($sformatf("%s latency", name), cyc - t0, lat);
            check($sformatf("%s byte%0d", name, idx), data, exp[idx]);
            idx++;
         end
      end
      i_tx_full = 1'b0;
      check($sformatf("%s bytes seen", name), idx, exp.size());
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst push", o_push, 0);
      check("rst data", o_tx_data, 8'h00);
      check("rst busy", o_busy, 0);
      check("rst drop", o_drop, 2'b00);
      step();
      rst = 1'b1;
      repeat (3) step();
      // simultaneous pair from reset: pointer at B so A wins first
      send_done(0, 2'b11, 12'd7, 12'd4000);
      expect_frame(0, "pair1 A", 8'h41, "0007", 14, -1, 0);
      expect_frame(0, "pair1 B", 8'h42, "4000", -1, -1, 0);
      // pointer now B, so A first again
      send_done(0, 2'b11, 12'd11, 12'd22);
      expect_frame(0, "pair2 A", 8'h41, "0011", 14, -1, 0);
      expect_frame(0, "pair2 B", 8'h42, "0022", -1, -1, 0);
      // single channel 0 frame and idle afterwards
      send_done(0, 2'b01, 12'd123, 12'd0);
      expect_frame(0, "ch0 123", 8'h41, "0123", 14, -1, 0);
      @(negedge clk);
      check("busy after frame", o_busy, 0);
      // backpressure for five cycles at byte 3
      send_done(0, 2'b01, 12'd123, 12'd0);
      expect_frame(0, "stall", 8'h41, "0123", 14, 3, 5);
      // overwrite of a pending ch0 sample while ch1 is being served
      send_done(0, 2'b10, 12'd0, 12'd5);
      i_done = 2'b01;
      i_data[11:0] = 12'd10;
      @(negedge clk);
      check("drop first", o_drop, 2'b00);
      step();
      i_done = 2'b00;
      step();
      i_done = 2'b01;
      i_data[11:0] = 12'd20;
      @(negedge clk);
      check("drop pulse", o_drop, 2'b01);
      check("drop busy", o_busy, 1);
      step();
      i_done = 2'b00;
      @(negedge clk);
      check("drop cleared", o_drop, 2'b00);
      expect_frame(0, "drop B", 8'h42, "0005", -1, -1, 0);
      expect_frame(0, "drop A", 8'h41, "0020", -1, -1, 0);
      // reset during byte 4 of a frame
      send_done(0, 2'b01, 12'd123, 12'd0);
      repeat (17) step();
      check("pre-rst push", o_push, 1);
      check("pre-rst data", o_tx_data, 8'h32);
      rst = 1'b0;
      #1;
      check("mid-rst push", o_push, 0);
      check("mid-rst busy", o_busy, 0);
      check("mid-rst data", o_tx_data, 8'h00);
      step();
      rst = 1'b1;
      np = 0;
      repeat (40) begin
         @(negedge clk);
         np += int'(o_push);
      end
      check("no push after rst", np, 0);
      send_done(0, 2'b01, 12'd55, 12'd0);
      expect_frame(0, "after rst", 8'h41, "0055", 14, -1, 0);
      // three-digit instance: saturation and plain value
      send_done(1, 2'b10, 12'd0, 12'd4095);
      expect_frame(1, "sat B", 8'h42, "999", 14, -1, 0);
      send_done(1, 2'b01, 12'd998, 12'd0);
      expect_frame(1, "d3 A", 8'h41, "998", 14, -1, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sensor_report_tx.md
# sensor_report_tx

Parametrised, multi-channel successor to the single-channel distance sender. Accepts completed measurements from up to N_CH sensor cores (SR04, DHT11, …), arbitrates round-robin, converts each binary value to fixed-width ASCII decimal and pushes a tagged, CR/LF-terminated frame byte-by-byte into the UART TX FIFO under `tx_full` backpressure. Sits between the sensor tops and `uart_top`, replacing `dat_to_asc` + `sender_uart`.

## Interface
- N_CH, 2, number of sensor channels (1..8)
- DATA_W, 12, measurement width per channel (4..20)
- DIGITS, 4, decimal digits per frame (1..6)
- TAG_BASE, 8'h41, ASCII tag of channel 0; channel k sends TAG_BASE+k
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- i_done  in  N_CH  per-channel one-cycle "measurement valid" pulse
- i_data  in  N_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W], sampled when i_done[k]=1
- i_tx_full  in  1  TX FIFO full; no push while high
- o_push  out  1  one-cycle FIFO write strobe
- o_tx_data  out  8  byte written when o_push=1
- o_busy  out  1  high whenever FSM not in IDLE
- o_drop  out  N_CH  one-cycle pulse: pending sample of channel k overwritten before being served

## Operation
- Per channel: shadow reg + pending flag. i_done[k] → shadow[k]=slice, pending[k]=1. If pending[k] already 1 → overwrite shadow, pulse o_drop[k] same cycle as register update.
- Arbiter: rr pointer = last granted channel (reset N_CH-1). Grant = first pending channel searching last+1 upward, wrapping. Grant clears pending[k], copies shadow[k] into working value, updates pointer.
- i_done[k] in the same cycle as grant of k: new sample stays pending (captured into shadow, pending remains 1), no drop.
- Saturation: working value ≥ 10^DIGITS → loaded as 10^DIGITS−1 (all '9').
- FSM: IDLE → (any pending) LOAD → CONV → SEND → IDLE.
  - LOAD: 1 cycle, grant + saturate.
  - CONV: DATA_W cycles shift-add-3 (double dabble) into 4*DIGITS BCD register.
  - SEND: frame = tag, 8'h3A ':', DIGITS digits MSD first (leading zeros kept, 8'h30+bcd), 8'h0D, 8'h0A; DIGITS+4 bytes. Byte index advances only on a push.
- o_push = (state==SEND) & ~i_tx_full; o_tx_data combinationally from byte index, stable while stalled.
- After last byte pushed → IDLE; re-arbitration next cycle.
- Reset values: o_push 0, o_tx_data 8'h00, o_busy 0, o_drop 0, all pending 0, state IDLE.

## Timing
- i_done in cycle 0 → pending at edge 0; LOAD in cycle 1; CONV cycles 2..DATA_W+1; first o_push in cycle DATA_W+2 if i_tx_full=0 (cycle 14 for defaults).
- Unstalled frame: DIGITS+4 consecutive push cycles; back-to-back frames separated by IDLE+LOAD+CONV (DATA_W+2 cycles).
- i_tx_full high: o_push held 0, byte/index frozen; push resumes the cycle i_tx_full drops.
- rst asserted mid-frame: outputs clear immediately (async); partial frame abandoned, no completion on release.
- First FSM action two edges after rst deasserts is allowed (sync release inside block).

## Structure
- Package `sensor_report_pkg`: FSM state enum, ASCII constants (COLON, CR, LF, ZERO), frame-length function of DIGITS, 10^DIGITS constant function.
- Sub-module `bin2bcd_seq` (start, value, done, bcd; DATA_W/DIGITS params) holds CONV datapath; arbiter and sender stay in top.

## Test plan
- Defaults, ch0 i_done with 12'd123 → bytes 41 3A 30 31 32 33 0D 0A, first push cycle 14, o_busy low after.
- Same-cycle i_done both channels (ch0=7, ch1=4000) → "A:0007\r\n" then "B:4000\r\n"; next simultaneous pair → A first again only if pointer says so (pointer=B → A).
- DIGITS=3, ch1 value 4095 → "B:999\r\n" (saturation).
- i_tx_full high for 5 cycles at byte 3 → o_push 0, o_tx_data held 8'h31; resumes, frame complete and in order.
- Two i_done on ch0 while ch1 frame in progress (10 then 20) → one o_drop[0] pulse, later frame "A:0020".
- rst low during byte 4 of a frame → o_push/o_busy 0 immediately; after release no bytes until a new i_done.
